// File: rtl/kij_sequencer.sv
// kij_sequencer: per-kernel-index pass controller for the PE array core.
// Each pass loads weights into L0, streams the PE array, executes len_nij
// pixels and drains the output FIFO into psum memory.
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   start        one-cycle request to run a pass (accepted only in IDLE)
//   kij[3:0]     kernel index 0..8, latched on accepted start
//   ofifo_valid  core output FIFO holds a complete row
//   inst[63:0]   registered instruction word to the core
//   busy         high while a pass is in progress
//   done         one-cycle pulse at end of pass
//   err          sticky error (bad kij or drain timeout), cleared by start
module kij_sequencer #(
    parameter int unsigned col       = 8,
    parameter int unsigned row       = 8,
    parameter int unsigned len_nij   = 36,
    parameter int unsigned in_w      = 6,
    parameter int unsigned out_w     = 4,
    parameter int unsigned gap       = 10,
    parameter int unsigned drain_max = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  kij,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(drain_max + len_nij + col + row + gap + 1);
    localparam int unsigned N_W   = $clog2(len_nij + 1);
    localparam int unsigned S_W   = N_W + 2;
    localparam int unsigned A_W   = 11;

    localparam int unsigned B_SFU      = 34;
    localparam int unsigned B_ACC      = 33;
    localparam int unsigned B_CEN_P    = 32;
    localparam int unsigned B_WEN_P    = 31;
    localparam int unsigned B_A_P      = 20;
    localparam int unsigned B_CEN_X    = 19;
    localparam int unsigned B_WEN_X    = 18;
    localparam int unsigned B_A_X      = 7;
    localparam int unsigned B_OFIFO_RD = 6;
    localparam int unsigned B_L0_RD    = 3;
    localparam int unsigned B_L0_WR    = 2;
    localparam int unsigned B_EXEC     = 1;
    localparam int unsigned B_LOAD     = 0;

    localparam logic [63:0] IDLE_WORD = (64'd1 << B_CEN_X) | (64'd1 << B_WEN_X) | (64'd1 << B_CEN_P);
    localparam logic signed [S_W-1:0] OUT_W_S = S_W'(out_w);

    typedef enum logic [2:0] {
        S_IDLE, S_L0W, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [N_W-1:0]   n, n_d;
    logic [3:0]       kij_q, kij_d;
    logic             err_d, busy_d, done_d;
    logic [63:0]      inst_d;
    logic             row_rd;

    logic [N_W-1:0]        r_idx, c_idx;
    logic [3:0]            ky, kx;
    logic signed [S_W-1:0] oy, ox;
    logic                  row_ok;
    logic [A_W-1:0]        a_pmem;

    // Output-map address of the row about to be read; signed so edge rows go negative.
    always_comb begin
        r_idx  = n / N_W'(in_w);
        c_idx  = n % N_W'(in_w);
        ky     = kij_q / 4'd3;
        kx     = kij_q % 4'd3;
        oy     = $signed(S_W'(r_idx)) - $signed(S_W'(ky));
        ox     = $signed(S_W'(c_idx)) - $signed(S_W'(kx));
        row_ok = !oy[S_W-1] && (oy < OUT_W_S) && !ox[S_W-1] && (ox < OUT_W_S);
        a_pmem = A_W'(oy) * A_W'(out_w) + A_W'(ox);
    end

    // Next-state and next instruction word.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        kij_d   = kij_q;
        err_d   = err;
        inst_d  = IDLE_WORD;
        done_d  = 1'b0;
        row_rd  = ((state == S_EXEC) || (state == S_DRAIN)) && ofifo_valid
                  && (n < N_W'(len_nij));
        n_d     = row_rd ? n + N_W'(1) : n;

        unique case (state)
            S_IDLE: begin
                // done is high in the first IDLE cycle after a pass; a start there is dropped.
                if (start && !done) begin
                    kij_d = kij;
                    err_d = 1'b0;
                    n_d   = '0;
                    cnt_d = '0;
                    if (kij > 4'd8) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_L0W;
                    end
                end
            end
            S_L0W: begin
                // SRAM read has one cycle latency, so L0 write trails the address by one.
                inst_d[B_CEN_X]          = 1'b0;
                inst_d[B_A_X +: A_W]     = A_W'(1024) + A_W'(cnt);
                inst_d[B_L0_WR]          = (cnt != '0);
                if (cnt == CNT_W'(col)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                inst_d[B_L0_RD] = 1'b1;
                inst_d[B_LOAD]  = (cnt != '0);
                if (cnt == CNT_W'(col + row)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(gap - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (cnt < CNT_W'(len_nij)) begin
                    inst_d[B_CEN_X]      = 1'b0;
                    inst_d[B_A_X +: A_W] = A_W'(cnt);
                end
                if (cnt != '0) begin
                    inst_d[B_L0_WR] = 1'b1;
                    inst_d[B_L0_RD] = 1'b1;
                    inst_d[B_EXEC]  = 1'b1;
                end
                if (cnt == CNT_W'(len_nij)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (n_d == N_W'(len_nij)) begin
                    state_d = S_DONE;
                end else if (cnt == CNT_W'(drain_max - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Row read: out-of-map rows are still popped from the FIFO but not written.
        if (row_rd) begin
            inst_d[B_OFIFO_RD]   = 1'b1;
            inst_d[B_CEN_P]      = !row_ok;
            inst_d[B_WEN_P]      = row_ok;
            inst_d[B_A_P +: A_W] = row_ok ? a_pmem : '0;
            inst_d[B_SFU]        = (kij_q == 4'd0);
            inst_d[B_ACC]        = (kij_q != 4'd0);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            n     <= '0;
            kij_q <= '0;
            err   <= 1'b0;
            inst  <= IDLE_WORD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            n     <= n_d;
            kij_q <= kij_d;
            err   <= err_d;
            inst  <= inst_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: doc/kij_sequencer.md
KIJ_SEQUENCER -- requirements
Module: kij_sequencer

Interface
REQ-001 Parameters: col 8 (PE array columns); row 8 (PE array rows); len_nij 36 (input pixels per pass); in_w 6 (input map width); out_w 4 (output map width); gap 10 (idle cycles between load and execute); drain_max 64 (drain timeout, cycles).
REQ-002 Port: clk, input, 1, single clock; all logic on rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: start, input, 1, one-cycle request to run one kij pass.
REQ-005 Port: kij, input, 4, kernel index 0..8; sampled only when start is accepted.
REQ-006 Port: ofifo_valid, input, 1, core output FIFO holds a complete row.
REQ-007 Port: inst, output, 64, registered instruction word to core.
REQ-008 Port: busy, output, 1, high from the cycle after start is accepted until done.
REQ-009 Port: done, output, 1, one-cycle pulse at end of pass.
REQ-010 Port: err, output, 1, sticky until next accepted start; set on bad kij or drain timeout.

Function
REQ-011 inst field map: [63] debug; [35] REN_pmem; [34] sfu_passthrough; [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem; [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem; [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-012 Unlisted bits, debug, ififo_wr, ififo_rd and REN_pmem are always 0.
REQ-013 Idle word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1; all other bits 0. WEN_xmem stays 1 in every state (reads only).
REQ-014 States: IDLE, L0W, LOAD, GAP, EXEC, DRAIN, DONE.
REQ-015 IDLE: emit the idle word. start=1 latches kij, clears err and the row counter, and goes to L0W. start is ignored outside IDLE.
REQ-016 Bad kij: start with kij>8 goes to DONE directly and sets err.
REQ-017 L0W, col+1 cycles, step i=0..col: CEN_xmem=0, A_xmem=1024+i (1024 for i=0); l0_wr=1 for i>=1 (one-cycle SRAM read latency).
REQ-018 LOAD, col+row+1 cycles: l0_rd=1 every cycle; load=1 in every cycle except the first.
REQ-019 GAP: idle word for gap cycles.
REQ-020 EXEC, len_nij+1 cycles, step i=0..len_nij:
- i<len_nij: CEN_xmem=0, A_xmem=i.
- i>=1: l0_wr=1, l0_rd=1, execute=1.
REQ-021 DRAIN: follows EXEC. Ends when len_nij rows have been read (go to DONE) or when drain_max cycles pass in DRAIN (set err, go to DONE).
REQ-022 Row read, EXEC or DRAIN, ofifo_valid=1 and rows read <len_nij: set ofifo_rd=1 in the same-cycle registered word, then increment the row counter n.
REQ-023 Output address for row n: r=n/in_w, c=n%in_w, ky=kij/3, kx=kij%3, oy=r-ky, ox=c-kx.
REQ-024 Row valid when 0<=oy<out_w and 0<=ox<out_w. Valid row: CEN_pmem=0, WEN_pmem=1, A_pmem=oy*out_w+ox (11 bits, zero-extended).
REQ-025 Invalid row: CEN_pmem=1, WEN_pmem=0; ofifo_rd=1 still (row discarded).
REQ-026 On every row read: sfu_passthrough=1, acc=0 if kij==0; otherwise sfu_passthrough=0, acc=1.
REQ-027 In a cycle with no row read: CEN_pmem=1, WEN_pmem=0, acc=0, sfu_passthrough=0, ofifo_rd=0.
REQ-028 Address arithmetic uses signed ≥5-bit intermediates; no wrap.
REQ-029 ofifo_valid is ignored outside EXEC/DRAIN; no read is issued.
REQ-030 DONE: one cycle; done=1, busy=0, idle word; then IDLE.
REQ-031 start coinciding with the done cycle is ignored.

Reset
REQ-032 reset=1 at any clock edge forces IDLE, the idle word on inst, busy=0, done=0, err=0, counters 0.
REQ-033 reset mid-pass aborts with no done pulse; reset has priority over start.

Verification
REQ-034 Reset check: reset for 3 cycles in EXEC -> next cycle inst = CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, all else 0; busy=0.
REQ-035 kij=0, ofifo_valid=1 from EXEC step 17 onward:
- Pass completes with done; err=0.
- Exactly 36 ofifo_rd pulses.
- 16 writes at A_pmem 0..15 in order, all with sfu_passthrough=1.
- Rows n=4,5,10,11 read with CEN_pmem=1.
REQ-036 kij=4 (ky=kx=1): row n=7 -> A_pmem=0, acc=1; row n=0 -> CEN_pmem=1; row n=28 -> A_pmem=15.
REQ-037 L0W/LOAD timing:
- A_xmem sweeps 1024..1032 over 9 cycles, with l0_wr=0 only on the first.
- Then 17 cycles of l0_rd, with load high on the last 16.
REQ-038 ofifo_valid never asserted -> err=1 and done exactly drain_max cycles after EXEC ends; a second start is ignored while busy.
REQ-039 start with kij=9 -> done pulse 2 cycles later, err=1, no xmem or pmem activity.
